packet_serializer: RTL and testbench

Downstream neighbour of the queueing/scheduling stage. It accepts one wide scheduled packet per valid/ready handshake on the `queues_to_serializer_*` interface and emits it as a sequence of `BEAT_WIDTH`-bit beats on a valid/ready/last stream toward the AXI-facing output logic. It also owns the ready signal the scheduler waits on, so it back-pressures scheduling decisions while a packet is still draining.

---
 rtl/packet_serializer_if.sv | 32 +++
 rtl/packet_serializer.sv | 88 ++++++++
 tb/tb_packet_serializer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/packet_serializer_if.sv
// Handshake bundle between the scheduler, the packet serializer and the beat sink.
// The master modport is the serializer's view; slave is the surrounding logic's view.
interface packet_serializer_if #(
  parameter int DATA_SIZE    = 678,
  parameter int BEAT_WIDTH   = 128,
  parameter int COUNTER_SIZE = 32
);
  localparam int NUMBER_OF_BEATS = (DATA_SIZE + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int INDEX_W         = (NUMBER_OF_BEATS > 1) ? $clog2(NUMBER_OF_BEATS) : 1;

  logic                    queues_to_serializer_valid;
  logic [DATA_SIZE-1:0]    queues_to_serializer_packet;
  logic                    serializer_to_scheduler_ready;
  logic                    beat_valid;
  logic [BEAT_WIDTH-1:0]   beat_data;
  logic                    beat_last;
  logic [INDEX_W-1:0]      beat_index;
  logic                    beat_ready;
  logic [COUNTER_SIZE-1:0] packets_sent;

  modport master (
    input  queues_to_serializer_valid, queues_to_serializer_packet, beat_ready,
    output serializer_to_scheduler_ready, beat_valid, beat_data, beat_last,
           beat_index, packets_sent
  );

  modport slave (
    output queues_to_serializer_valid, queues_to_serializer_packet, beat_ready,
    input  serializer_to_scheduler_ready, beat_valid, beat_data, beat_last,
           beat_index, packets_sent
  );
endinterface

// File: rtl/packet_serializer.sv
// Splits one wide scheduled packet into BEAT_WIDTH-bit beats (LSBs first) on a
// valid/ready/last stream, back-pressuring the scheduler until the last beat leaves.
module packet_serializer #(
  parameter int DATA_SIZE    = 678,
  parameter int BEAT_WIDTH   = 128,
  parameter int COUNTER_SIZE = 32
) (
  input  logic                clock,
  input  logic                reset,
  packet_serializer_if.master bus
);
  localparam int NUMBER_OF_BEATS = (DATA_SIZE + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int INDEX_W         = (NUMBER_OF_BEATS > 1) ? $clog2(NUMBER_OF_BEATS) : 1;
  localparam int PADDED_W        = NUMBER_OF_BEATS * BEAT_WIDTH;
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUMBER_OF_BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q,        state_d;
  logic [PADDED_W-1:0]     padded_q,       padded_d;
  logic [INDEX_W-1:0]      beat_index_q,   beat_index_d;
  logic                    beat_last_q,    beat_last_d;
  logic [COUNTER_SIZE-1:0] packets_sent_q, packets_sent_d;

  // NOTE: every always_comb output is given its hold value first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    padded_d       = padded_q;
    beat_index_d   = beat_index_q;
    beat_last_d    = beat_last_q;
    packets_sent_d = packets_sent_q;

    case (state_q)
      IDLE: begin
        if (bus.queues_to_serializer_valid) begin
          padded_d     = PADDED_W'(bus.queues_to_serializer_packet);
          beat_index_d = '0;
          beat_last_d  = (NUMBER_OF_BEATS == 1);
          state_d      = SEND;
        end
      end
      SEND: begin
        if (bus.beat_ready) begin
          // The current beat always sits in the low slice; shifting keeps the
          // output a plain wire off the register and zero-fills behind it.
          padded_d = padded_q >> BEAT_WIDTH;
          if (beat_last_q) begin
            beat_index_d   = '0;
            beat_last_d    = 1'b0;
            packets_sent_d = packets_sent_q + 1'b1;
            state_d        = IDLE;
          end else begin
            beat_index_d = beat_index_q + 1'b1;
            beat_last_d  = (INDEX_W'(beat_index_q + 1'b1) == LAST_INDEX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the wide packet register is reset too, because beat_data is read
  // straight from it and must be zero out of reset; state uses <= so every
  // flop samples the pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      padded_q       <= '0;
      beat_index_q   <= '0;
      beat_last_q    <= 1'b0;
      packets_sent_q <= '0;
    end else begin
      state_q        <= state_d;
      padded_q       <= padded_d;
      beat_index_q   <= beat_index_d;
      beat_last_q    <= beat_last_d;
      packets_sent_q <= packets_sent_d;
    end
  end

  assign bus.serializer_to_scheduler_ready = (state_q == IDLE);
  assign bus.beat_valid                    = (state_q == SEND);
  assign bus.beat_data                     = padded_q[BEAT_WIDTH-1:0];
  assign bus.beat_last                     = beat_last_q;
  assign bus.beat_index                    = beat_index_q;
  assign bus.packets_sent                  = packets_sent_q;
endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: directed sequences with random data, checked
// against a queue of expected beats sliced arithmetically from each packet.
module tb_packet_serializer;
  localparam int DS = 678;
  localparam int BW = 128;
  localparam int CS = 32;
  localparam int NB = 6;
  localparam int PW = NB * BW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  packet_serializer_if #(.DATA_SIZE(DS), .BEAT_WIDTH(BW), .COUNTER_SIZE(CS)) bus ();
  packet_serializer #(.DATA_SIZE(DS), .BEAT_WIDTH(BW), .COUNTER_SIZE(CS)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  packet_serializer_if #(.DATA_SIZE(128), .BEAT_WIDTH(128), .COUNTER_SIZE(CS)) sbus ();
  packet_serializer #(.DATA_SIZE(128), .BEAT_WIDTH(128), .COUNTER_SIZE(CS)) sdut (
    .clock(clock), .reset(reset), .bus(sbus)
  );

  typedef struct {
    logic [BW-1:0] data;
    int            idx;
    bit            last;
  } beat_t;

  beat_t       exp_q[$];
  int          accept_cyc[$];
  logic [31:0] exp_sent = '0;
  int          cyc = 0;
  int          ready_low = 0;
  logic [BW-1:0] last_obs = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DS-1:0] rand_pkt();
    logic [703:0] tmp;
    for (int w = 0; w < 704; w += 32) tmp[w +: 32] = $urandom;
    return tmp[DS-1:0];
  endfunction

  function automatic logic [DS-1:0] asc_pkt();
    logic [679:0] tmp;
    for (int b = 0; b < 85; b++) tmp[b*8 +: 8] = 8'(b);
    return tmp[DS-1:0];
  endfunction

  // Expected beats: packet zero-extended, then cut into NB slices, LSB slice first.
  function automatic void load_model(input logic [DS-1:0] pkt);
    logic [PW-1:0] padded;
    beat_t b;
    padded = '0;
    padded[DS-1:0] = pkt;
    for (int k = 0; k < NB; k++) begin
      b.data = padded[k*BW +: BW];
      b.idx  = k;
      b.last = (k == NB - 1);
      exp_q.push_back(b);
    end
  endfunction

  // One clock: drive at negedge, compare just after, predict the coming edge.
  task automatic step(input bit v, input logic [DS-1:0] pkt, input bit br);
    @(negedge clock);
    bus.queues_to_serializer_valid  = v;
    bus.queues_to_serializer_packet = pkt;
    bus.beat_ready                  = br;
    #1;
    check("packets_sent", bus.packets_sent, exp_sent);
    if (!bus.serializer_to_scheduler_ready) ready_low++;
    if (exp_q.size() == 0) begin
      check("ready_idle", bus.serializer_to_scheduler_ready, 1);
      check("valid_idle", bus.beat_valid, 0);
      if (v) begin
        load_model(pkt);
        accept_cyc.push_back(cyc);
      end
    end else begin
      check("ready_send", bus.serializer_to_scheduler_ready, 0);
      check("beat_valid", bus.beat_valid, 1);
      check("beat_data", bus.beat_data, exp_q[0].data);
      check("beat_index", BW'(bus.beat_index), BW'(exp_q[0].idx));
      check("beat_last", bus.beat_last, exp_q[0].last);
      if (br) begin
        if (exp_q[0].last) begin
          exp_sent = exp_sent + 1;
          last_obs = bus.beat_data;
        end
        void'(exp_q.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, bus.serializer_to_scheduler_ready, 1);
    check({tag, "_valid"}, bus.beat_valid, 0);
    check({tag, "_data"},  bus.beat_data, 0);
    check({tag, "_last"},  bus.beat_last, 0);
    check({tag, "_index"}, BW'(bus.beat_index), 0);
    check({tag, "_sent"},  bus.packets_sent, 0);
  endtask

  initial begin
    logic [DS-1:0] pa, pb, pc;
    logic [127:0]  s_exp;
    bit            s_busy;
    logic [31:0]   s_sent;
    int            s_acc[$];

    bus.queues_to_serializer_valid   = 1'b0;
    bus.queues_to_serializer_packet  = '0;
    bus.beat_ready                   = 1'b0;
    sbus.queues_to_serializer_valid  = 1'b0;
    sbus.queues_to_serializer_packet = '0;
    sbus.beat_ready                  = 1'b0;

    // Reset values.
    repeat (2) @(negedge clock);
    #1;
    check_reset_values("rst");
    @(negedge clock);
    #2 reset = 1'b1;

    // Single ascending-byte packet, no stalls.
    ready_low = 0;
    step(1'b1, asc_pkt(), 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    check("t1_ready_low_cycles", BW'(ready_low), 6);
    check("t1_last_beat_pad", BW'(last_obs[127:38]), 0);
    check("t1_last_beat_bits", BW'(last_obs[37:0]), BW'(asc_pkt() >> 640));
    check("t1_sent", bus.packets_sent, 1);

    // Same packet with stalls: 1,0,0,1 then random.
    step(1'b1, asc_pkt(), 1'b1);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++)
      step(1'b0, '0, (i < 4) ? ((i == 0) || (i == 3)) : 1'($urandom_range(0, 1)));
    check("t2_drain_bound", BW'(exp_q.size()), 0);
    step(1'b0, '0, 1'b1);
    check("t2_sent", bus.packets_sent, 2);

    // Back-to-back A then B with valid held.
    pa = rand_pkt();
    pb = rand_pkt();
    accept_cyc.delete();
    for (int i = 0; i < 16; i++)
      step(accept_cyc.size() < 2, (accept_cyc.size() == 0) ? pa : pb, 1'b1);
    check("t3_accepts", BW'(accept_cyc.size()), 2);
    if (accept_cyc.size() == 2)
      check("t3_b_after_a", BW'(accept_cyc[1] - accept_cyc[0]), 7);
    check("t3_sent", bus.packets_sent, 4);

    // Reset mid-packet after beat 2 has transferred.
    step(1'b1, rand_pkt(), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    exp_sent = '0;
    @(negedge clock);
    #2 reset = 1'b1;
    pc = rand_pkt();
    step(1'b1, pc, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    check("t4_sent_only_c", bus.packets_sent, 1);

    // Counter wrap from all-ones.
    @(negedge clock);
    force dut.packets_sent_q = 32'hFFFF_FFFF;
    @(posedge clock);
    @(negedge clock);
    release dut.packets_sent_q;
    exp_sent = 32'hFFFF_FFFF;
    step(1'b1, rand_pkt(), 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    check("t5_wrap", bus.packets_sent, 0);

    // Single-beat configuration: valid and beat_ready held high.
    s_busy = 1'b0;
    s_sent = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      sbus.queues_to_serializer_valid  = 1'b1;
      sbus.queues_to_serializer_packet = {$urandom, $urandom, $urandom, $urandom};
      sbus.beat_ready                  = 1'b1;
      #1;
      check("s_sent", sbus.packets_sent, s_sent);
      if (s_busy) begin
        check("s_valid", sbus.beat_valid, 1);
        check("s_ready", sbus.serializer_to_scheduler_ready, 0);
        check("s_data", sbus.beat_data, s_exp);
        check("s_last", sbus.beat_last, 1);
        check("s_index", BW'(sbus.beat_index), 0);
        s_busy = 1'b0;
        s_sent = s_sent + 1;
      end else begin
        check("s_ready_idle", sbus.serializer_to_scheduler_ready, 1);
        s_exp  = sbus.queues_to_serializer_packet;
        s_busy = 1'b1;
        s_acc.push_back(i);
      end
    end
    check("s_accepts", BW'(s_acc.size()), 6);
    for (int k = 1; k < s_acc.size(); k++)
      check("s_throughput", BW'(s_acc[k] - s_acc[k-1]), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
